sipo_deser: RTL and testbench

- Serial-in parallel-out receiver. It is the receive end of the team's PISO serial link.
- Samples one serial bit per enabled clock and assembles WIDTH-bit words.
- Presents each finished word on a holding register with a valid/acknowledge handshake.
- Reports overrun when a new word completes before the previous one has been taken, and supports resynchronisation of word framing.

---
 rtl/sipo_deser.sv | 117 +++++++++++
 tb/tb_sipo_deser.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sipo_deser.sv
// Serial-in parallel-out receiver for the PISO serial link.
// Assembles WIDTH-bit words and hands them off via valid/rd_ack.
module sipo_deser #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             D,
  input  logic             shift_en,
  input  logic             sync,
  input  logic             rd_ack,
  output logic [WIDTH-1:0] Q,
  output logic             valid,
  output logic             busy,
  output logic             overrun
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  logic [WIDTH-1:0] sr, sr_d;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] word;
  logic [CW-1:0]    cnt, cnt_d;
  logic             valid_d;
  logic             ovr_d;
  logic             take;
  logic             last;
  state_t           st;

  // Framing state is the bit counter itself: idle at zero.
  always_comb begin
    st = (cnt == '0) ? IDLE : RECV;
  end

  // Word as it would look with this cycle's bit shifted in.
  always_comb begin
    word = MSB_FIRST ? {sr[WIDTH-2:0], D}
                     : {D, sr[WIDTH-1:1]};
  end

  // Next-state for framing, holding register and handshake.
  always_comb begin
    sr_d    = sr;
    cnt_d   = cnt;
    q_d     = Q;
    valid_d = valid;
    ovr_d   = overrun;
    take    = valid & rd_ack;
    last    = 1'b0;

    if (take) begin
      valid_d = 1'b0;
    end

    if (sync) begin
      sr_d  = '0;
      cnt_d = '0;
      ovr_d = 1'b0;
    end else if (shift_en) begin
      sr_d = word;
      unique case (st)
        IDLE: begin
          cnt_d = CW'(1);
        end
        RECV: begin
          if (cnt == LAST) begin
            last  = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
        default: begin
          cnt_d = '0;
        end
      endcase
      if (last) begin
        if (!valid || rd_ack) begin
          q_d     = word;
          valid_d = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr      <= '0;
      cnt     <= '0;
      Q       <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      sr      <= sr_d;
      cnt     <= cnt_d;
      Q       <= q_d;
      valid   <= valid_d;
      overrun <= ovr_d;
    end
  end

  // A partial word is in flight whenever the counter is nonzero.
  always_comb begin
    busy = (cnt != '0);
  end

endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: directed vector table plus randomized run
// against a queue-based reference, both bit orders in parallel.
module tb_sipo_deser;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, d, se, sy, ack;
  logic [W-1:0] q1, q0;
  logic         v1, b1, o1, v0, b0, o0;

  int errors = 0;
  int checks = 0;

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .D(d), .shift_en(se),
    .sync(sy), .rd_ack(ack), .Q(q1), .valid(v1),
    .busy(b1), .overrun(o1)
  );

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .D(d), .shift_en(se),
    .sync(sy), .rd_ack(ack), .Q(q0), .valid(v0),
    .busy(b0), .overrun(o0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst, d, se, sy, ack;
    logic [W-1:0] q1, q0;
    logic         v, b, o;
  } vec_t;

  vec_t vt[$];

  // reference model state
  bit           mbits[$];
  logic [W-1:0] mq1, mq0;
  logic         mv, mov;

  function automatic vec_t mk(
    logic r, logic dd, logic s, logic y, logic a,
    logic [W-1:0] e1, logic [W-1:0] e0,
    logic ev, logic eb, logic eo);
    vec_t x;
    x.rst = r; x.d = dd; x.se = s; x.sy = y; x.ack = a;
    x.q1 = e1; x.q0 = e0; x.v = ev; x.b = eb; x.o = eo;
    return x;
  endfunction

  task automatic model_step(logic r, logic dd, logic s,
                            logic y, logic a);
    logic         nv;
    logic [W-1:0] w1, w0;
    if (r) begin
      mbits.delete();
      mq1 = '0; mq0 = '0; mv = 1'b0; mov = 1'b0;
    end else begin
      nv = mv && !(mv && a);
      if (y) begin
        mbits.delete();
        mov = 1'b0;
      end else if (s) begin
        mbits.push_back(dd);
        if (mbits.size() == W) begin
          for (int i = 0; i < W; i++) begin
            w1[W-1-i] = mbits[i];
            w0[i]     = mbits[i];
          end
          mbits.delete();
          if (nv) mov = 1'b1;
          else begin
            mq1 = w1; mq0 = w0; nv = 1'b1;
          end
        end
      end
      mv = nv;
    end
  endtask

  task automatic check(string nm, logic [W-1:0] e1,
                       logic [W-1:0] e0, logic ev,
                       logic eb, logic eo);
    logic [2*W+5:0] got, exp;
    got = {q1, v1, b1, o1, q0, v0, b0, o0};
    exp = {e1, ev, eb, eo, e0, ev, eb, eo};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got q1=%b v/b/o=%b%b%b q0=%b v/b/o=%b%b%b want q1=%b q0=%b v/b/o=%b%b%b",
               nm, q1, v1, b1, o1, q0, v0, b0, o0,
               e1, e0, ev, eb, eo);
    end
  endtask

  task automatic apply(logic r, logic dd, logic s,
                       logic y, logic a);
    rst = r; d = dd; se = s; sy = y; ack = a;
    @(posedge clk);
    model_step(r, dd, s, y, a);
    #1;
  endtask

  task automatic idle3();
    for (int k = 0; k < 3; k++)
      vt.push_back(mk(0,0,0,0,0,4'b0000,4'b0000,0,1,0));
  endtask

  initial begin
    rst = 1'b1; d = 1'b0; se = 1'b0; sy = 1'b0; ack = 1'b0;

    // reset
    vt.push_back(mk(1,0,0,0,0,4'b0000,4'b0000,0,0,0));
    // 1,0,1,0 back to back
    vt.push_back(mk(0,1,1,0,0,4'b0000,4'b0000,0,1,0));
    vt.push_back(mk(0,0,1,0,0,4'b0000,4'b0000,0,1,0));
    vt.push_back(mk(0,1,1,0,0,4'b0000,4'b0000,0,1,0));
    vt.push_back(mk(0,0,1,0,0,4'b1010,4'b0101,1,0,0));
    // ack clears valid, Q holds
    vt.push_back(mk(0,0,0,0,1,4'b1010,4'b0101,0,0,0));
    // 1,1,0,0 with 3-cycle gaps
    vt.push_back(mk(0,1,1,0,0,4'b1010,4'b0101,0,1,0));
    vt.push_back(mk(0,0,0,0,0,4'b1010,4'b0101,0,1,0));
    vt.push_back(mk(0,0,0,0,0,4'b1010,4'b0101,0,1,0));
    vt.push_back(mk(0,0,0,0,0,4'b1010,4'b0101,0,1,0));
    vt.push_back(mk(0,1,1,0,0,4'b1010,4'b0101,0,1,0));
    vt.push_back(mk(0,0,0,0,0,4'b1010,4'b0101,0,1,0));
    vt.push_back(mk(0,1,0,0,0,4'b1010,4'b0101,0,1,0));
    vt.push_back(mk(0,0,0,0,0,4'b1010,4'b0101,0,1,0));
    vt.push_back(mk(0,0,1,0,0,4'b1010,4'b0101,0,1,0));
    vt.push_back(mk(0,1,0,0,0,4'b1010,4'b0101,0,1,0));
    vt.push_back(mk(0,1,0,0,0,4'b1010,4'b0101,0,1,0));
    vt.push_back(mk(0,1,0,0,0,4'b1010,4'b0101,0,1,0));
    vt.push_back(mk(0,0,1,0,0,4'b1100,4'b0011,1,0,0));
    vt.push_back(mk(0,0,0,0,1,4'b1100,4'b0011,0,0,0));
    // overrun: 1010 unread, then 0110
    vt.push_back(mk(0,1,1,0,0,4'b1100,4'b0011,0,1,0));
    vt.push_back(mk(0,0,1,0,0,4'b1100,4'b0011,0,1,0));
    vt.push_back(mk(0,1,1,0,0,4'b1100,4'b0011,0,1,0));
    vt.push_back(mk(0,0,1,0,0,4'b1010,4'b0101,1,0,0));
    vt.push_back(mk(0,0,1,0,0,4'b1010,4'b0101,1,1,0));
    vt.push_back(mk(0,1,1,0,0,4'b1010,4'b0101,1,1,0));
    vt.push_back(mk(0,1,1,0,0,4'b1010,4'b0101,1,1,0));
    vt.push_back(mk(0,0,1,0,0,4'b1010,4'b0101,1,0,1));
    // sync with a shifted bit: bit dropped, overrun cleared
    vt.push_back(mk(0,1,1,1,0,4'b1010,4'b0101,1,0,0));
    // 1100 with ack on the completing edge
    vt.push_back(mk(0,1,1,0,0,4'b1010,4'b0101,1,1,0));
    vt.push_back(mk(0,1,1,0,0,4'b1010,4'b0101,1,1,0));
    vt.push_back(mk(0,0,1,0,0,4'b1010,4'b0101,1,1,0));
    vt.push_back(mk(0,0,1,0,1,4'b1100,4'b0011,1,0,0));
    vt.push_back(mk(0,0,0,0,1,4'b1100,4'b0011,0,0,0));
    // 1,1 then sync, then 0,0,0,1
    vt.push_back(mk(0,1,1,0,0,4'b1100,4'b0011,0,1,0));
    vt.push_back(mk(0,1,1,0,0,4'b1100,4'b0011,0,1,0));
    vt.push_back(mk(0,0,0,1,0,4'b1100,4'b0011,0,0,0));
    vt.push_back(mk(0,0,1,0,0,4'b1100,4'b0011,0,1,0));
    vt.push_back(mk(0,0,1,0,0,4'b1100,4'b0011,0,1,0));
    vt.push_back(mk(0,0,1,0,0,4'b1100,4'b0011,0,1,0));
    vt.push_back(mk(0,1,1,0,0,4'b0001,4'b1000,1,0,0));
    // 1,0 then rst, then 1,1,1,1
    vt.push_back(mk(0,1,1,0,0,4'b0001,4'b1000,1,1,0));
    vt.push_back(mk(0,0,1,0,0,4'b0001,4'b1000,1,1,0));
    vt.push_back(mk(1,1,1,1,1,4'b0000,4'b0000,0,0,0));
    vt.push_back(mk(0,1,1,0,0,4'b0000,4'b0000,0,1,0));
    vt.push_back(mk(0,1,1,0,0,4'b0000,4'b0000,0,1,0));
    vt.push_back(mk(0,1,1,0,0,4'b0000,4'b0000,0,1,0));
    vt.push_back(mk(0,1,1,0,0,4'b1111,4'b1111,1,0,0));
    // ack while not valid is ignored
    vt.push_back(mk(0,0,0,0,1,4'b1111,4'b1111,0,0,0));
    vt.push_back(mk(0,0,0,0,1,4'b1111,4'b1111,0,0,0));

    for (int i = 0; i < vt.size(); i++) begin
      apply(vt[i].rst, vt[i].d, vt[i].se, vt[i].sy, vt[i].ack);
      check($sformatf("vec%0d", i), vt[i].q1, vt[i].q0,
            vt[i].v, vt[i].b, vt[i].o);
    end

    // randomized run against the reference model
    apply(1, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      logic r, dd, s, y, a;
      r  = ($urandom_range(0, 99) == 0);
      dd = 1'($urandom());
      s  = ($urandom_range(0, 3) != 0);
      y  = ($urandom_range(0, 24) == 0);
      a  = ($urandom_range(0, 3) == 0);
      apply(r, dd, s, y, a);
      check($sformatf("rnd%0d", i), mq1, mq0, mv,
            (mbits.size() != 0), mov);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
